ram_bist: RTL and testbench
===========================

Name: ram_bist

Overview:
Parametrised built-in self-test controller for single-port synchronous RAMs; the successor to the fixed 8-bit/32-entry write-then-read driver.
- Drives a RAM's en/we/addr/din port and writes a selectable data pattern to every address.
- Reads every address back, with configurable read latency, and compares against the expected pattern.
- Reports pass/fail, a saturating error count and the first failing address.
- Sits between a top-level test wrapper and any single-port RAM instance.

Parameters:
DATA_W, 8, RAM data width (>=2)
ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W
RD_LAT, 1, cycles from read-address clock edge to valid ram_rd_data (1..3)
ERR_W, 8, width of error counter

Ports:
sys_clk  in  1  clock, all logic rising-edge
sys_rst  in  1  asynchronous reset, active-low
start  in  1  level/pulse; sampled only in IDLE
mode  in  2  pattern select, latched at start
seed  in  DATA_W  pattern seed, latched at start
busy  out  1  high in WRITE, READ, DRAIN
done  out  1  one-cycle pulse at end of test
pass  out  1  valid after done; held until next accepted start
err_cnt  out  ERR_W  saturating mismatch count
first_err_addr  out  ADDR_W  address of first mismatch
ram_en  out  1  RAM enable
ram_we  out  1  1 = write, 0 = read
ram_addr  out  ADDR_W  RAM address
ram_wr_data  out  DATA_W  RAM write data
ram_rd_data  in  DATA_W  RAM read data, valid RD_LAT cycles after the read edge

Behaviour:
- Reset (sys_rst=0, asynchronous): state=IDLE; all outputs 0; delay line cleared. Mid-test reset aborts with no done pulse; RAM contents are undefined.
- Pattern P(a), with a zero-extended or truncated to DATA_W:
  - mode0: seed+a
  - mode1: ~(seed+a)
  - mode2: a[0] ? ~seed : seed
  - mode3: seed rotated left by (a mod DATA_W)
  - All arithmetic is modulo 2**DATA_W.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - ram_en=0.
  - start=1 -> latch mode/seed, clear err_cnt, first_err_addr and pass, addr=0, go to WRITE.
- WRITE:
  - ram_en=1, ram_we=1, ram_addr=addr, ram_wr_data=P(addr).
  - addr increments each cycle; at addr=DEPTH-1 -> READ, addr wraps to 0.
- READ:
  - ram_en=1, ram_we=0.
  - Each cycle pushes {valid, addr, P(addr)} into an RD_LAT-deep delay line.
  - At addr=DEPTH-1 -> DRAIN.
- DRAIN:
  - ram_en=0, ram_we=0.
  - Stays until the delay line is empty (RD_LAT cycles), then -> DONE.
- DONE: done=1 and pass=(err_cnt==0) for exactly one cycle, then -> IDLE. busy=0.
- Compare, whenever the delay-line output is valid:
  - Mismatch condition: ram_rd_data != expected.
  - On mismatch, err_cnt increments, saturating at 2**ERR_W-1.
  - If err_cnt was 0 before the increment, first_err_addr = the delayed addr.
- Timing: done asserts exactly 2*DEPTH+RD_LAT+1 cycles after the cycle in which start was sampled. For defaults this is cycle 66.
- start while busy or in DONE is ignored. start held high re-launches from IDLE on the cycle after DONE.
- err_cnt, first_err_addr and pass hold after DONE until the next accepted start.

Decomposition:
- Package ram_bist_pkg holds:
  - state enum
  - mode encodings MODE_INC, MODE_INV, MODE_CHK, MODE_ROT
  - pattern function P(mode, seed, addr)
- Sub-module ram_bist_dly: parametrised RD_LAT-stage shift register carrying {valid, addr, expected}. It has the same asynchronous active-low reset.

Test Plan:
1. Defaults, ideal RAM model (RD_LAT=1), mode0 seed 0x00 -> writes addr n / data n for n=0..31; done at cycle 66; pass=1, err_cnt=0, busy high for 65 cycles.
2. mode2 seed 0x55 -> ram_wr_data alternates 0x55, 0xAA, 0x55 ... from addr 0; pass=1.
3. Fault model with read bit3 stuck-at-1 at addr 5, mode0 seed 0 -> expected 0x05, read 0x0D; err_cnt=1, first_err_addr=5, pass=0.
4. RD_LAT=2 with a 2-cycle RAM model, mode3 seed 0x81 -> addr 1 writes 0x03; done at cycle 67; pass=1.
5. ERR_W=4, model returns ~data always -> err_cnt saturates at 15, first_err_addr=0, pass=0.
6. sys_rst low mid-READ -> all outputs 0 immediately, no done. start pulsed during WRITE -> ignored, test completes on the original timing.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and the data-pattern generator for the single-port RAM BIST controller.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_INC = 2'd0,
        MODE_INV = 2'd1,
        MODE_CHK = 2'd2,
        MODE_ROT = 2'd3
    } mode_t;

    // Computed on 64 bits and masked to the requested width, so callers of any DATA_W up to 64 share it.
    function automatic logic [63:0] bist_pattern(input mode_t mode, input logic [63:0] seed,
                                                 input logic [63:0] addr, input int unsigned width);
        logic [63:0] mask;
        logic [63:0] sum;
        logic [63:0] sh;
        logic [63:0] res;
        mask = (width >= 32'd64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        sum  = seed + addr;
        sh   = addr % 64'(width);
        case (mode)
            MODE_INC: res = sum;
            MODE_INV: res = ~sum;
            MODE_CHK: res = addr[0] ? ~seed : seed;
            MODE_ROT: res = (seed << sh) | (seed >> (64'(width) - sh));
            default:  res = seed;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/ram_bist_dly.sv
// RD_LAT-deep shift register pairing each issued read with its address and expected data.
module ram_bist_dly
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              push_vld,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_exp,
    output logic              pop_vld,
    output logic [ADDR_W-1:0] pop_addr,
    output logic [DATA_W-1:0] pop_exp,
    output logic              pend
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] stage_r [RD_LAT];

    // Shift one stage per cycle; stage 0 takes the new read, the last stage meets ram_rd_data.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_r[i] <= {ENTRY_W{1'b0}};
            end
        end else begin
            stage_r[0] <= {push_vld, push_addr, push_exp};
            for (int i = 1; i < RD_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign {pop_vld, pop_addr, pop_exp} = stage_r[RD_LAT-1];

    // Reads still in flight behind the output stage.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pend = pend | stage_r[i][ENTRY_W-1];
        end
    end

endmodule

// File: rtl/ram_bist.sv
// BIST controller: writes a pattern to every RAM address, reads it back through a latency-matched
// delay line and reports pass/fail, a saturating error count and the first failing address.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam logic [ERR_W-1:0]  ERR_ZERO  = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    state_t             state_r, state_nxt_s;
    logic [ADDR_W-1:0]  addr_r, addr_nxt_s;
    mode_t              mode_r, mode_nxt_s;
    logic [DATA_W-1:0]  seed_r, seed_nxt_s;
    logic               accept_s;

    logic [DATA_W-1:0]  pat_cur_s, pat_nxt_s;
    logic               wr_nxt_s, rd_nxt_s, drain_nxt_s;

    logic               dly_vld_s, dly_pend_s;
    logic [ADDR_W-1:0]  dly_addr_s;
    logic [DATA_W-1:0]  dly_exp_s;
    logic               miss_s;

    logic [ERR_W-1:0]   err_cnt_r, err_cnt_nxt_s;
    logic [ADDR_W-1:0]  first_err_r, first_err_nxt_s;
    logic               pass_r, pass_nxt_s;
    logic               busy_r, done_r;
    logic               ram_en_r, ram_we_r;
    logic [ADDR_W-1:0]  ram_addr_r;
    logic [DATA_W-1:0]  ram_wr_data_r;

    // Expected data for the address being issued now and for the one issued next cycle.
    assign pat_cur_s = DATA_W'(bist_pattern(mode_r, 64'(seed_r), 64'(addr_r), DATA_W));
    assign pat_nxt_s = DATA_W'(bist_pattern(mode_nxt_s, 64'(seed_nxt_s), 64'(addr_nxt_s), DATA_W));

    // FSM and test-context registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_r <= IDLE;
            addr_r  <= ADDR_ZERO;
            mode_r  <= MODE_INC;
            seed_r  <= DATA_ZERO;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            mode_r  <= mode_nxt_s;
            seed_r  <= seed_nxt_s;
        end
    end

    // Next-state, address sweep and start acceptance.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        mode_nxt_s  = mode_r;
        seed_nxt_s  = seed_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    mode_nxt_s  = mode_t'(mode);
                    seed_nxt_s  = seed;
                    addr_nxt_s  = ADDR_ZERO;
                    state_nxt_s = WRITE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITE: begin
                if (addr_r == ADDR_LAST) begin
                    state_nxt_s = READ;
                    addr_nxt_s  = ADDR_ZERO;
                end else begin
                    addr_nxt_s  = addr_r + ADDR_ONE;
                end
            end
            READ: begin
                if (addr_r == ADDR_LAST) begin
                    state_nxt_s = DRAIN;
                    addr_nxt_s  = ADDR_ZERO;
                end else begin
                    addr_nxt_s  = addr_r + ADDR_ONE;
                end
            end
            DRAIN: begin
                if (!dly_pend_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    ram_bist_dly #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_dly (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .push_vld  (state_r == READ),
        .push_addr (addr_r),
        .push_exp  (pat_cur_s),
        .pop_vld   (dly_vld_s),
        .pop_addr  (dly_addr_s),
        .pop_exp   (dly_exp_s),
        .pend      (dly_pend_s)
    );

    // Result bookkeeping; pass is resolved with the count that includes the final compare.
    always_comb begin
        miss_s          = dly_vld_s && (ram_rd_data != dly_exp_s);
        err_cnt_nxt_s   = err_cnt_r;
        first_err_nxt_s = first_err_r;
        pass_nxt_s      = pass_r;
        if (accept_s) begin
            err_cnt_nxt_s   = ERR_ZERO;
            first_err_nxt_s = ADDR_ZERO;
            pass_nxt_s      = 1'b0;
        end else begin
            if (miss_s && (err_cnt_r != ERR_MAX)) begin
                err_cnt_nxt_s = err_cnt_r + ERR_ONE;
            end else begin
                err_cnt_nxt_s = err_cnt_r;
            end
            if (miss_s && (err_cnt_r == ERR_ZERO)) begin
                first_err_nxt_s = dly_addr_s;
            end else begin
                first_err_nxt_s = first_err_r;
            end
            if (state_nxt_s == DONE) begin
                pass_nxt_s = (err_cnt_nxt_s == ERR_ZERO);
            end else begin
                pass_nxt_s = pass_r;
            end
        end
    end

    assign wr_nxt_s    = (state_nxt_s == WRITE);
    assign rd_nxt_s    = (state_nxt_s == READ);
    assign drain_nxt_s = (state_nxt_s == DRAIN);

    // Output registers, loaded from next-state values so they line up with the state register.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            err_cnt_r     <= ERR_ZERO;
            first_err_r   <= ADDR_ZERO;
            ram_en_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= ADDR_ZERO;
            ram_wr_data_r <= DATA_ZERO;
        end else begin
            busy_r        <= wr_nxt_s || rd_nxt_s || drain_nxt_s;
            done_r        <= (state_nxt_s == DONE);
            pass_r        <= pass_nxt_s;
            err_cnt_r     <= err_cnt_nxt_s;
            first_err_r   <= first_err_nxt_s;
            ram_en_r      <= wr_nxt_s || rd_nxt_s;
            ram_we_r      <= wr_nxt_s;
            ram_addr_r    <= (wr_nxt_s || rd_nxt_s) ? addr_nxt_s : ADDR_ZERO;
            ram_wr_data_r <= wr_nxt_s ? pat_nxt_s : DATA_ZERO;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_cnt        = err_cnt_r;
    assign first_err_addr = first_err_r;
    assign ram_en         = ram_en_r;
    assign ram_we         = ram_we_r;
    assign ram_addr       = ram_addr_r;
    assign ram_wr_data    = ram_wr_data_r;

endmodule

// File: tb/tb_ram_bist.sv
// Two BIST instances (RD_LAT=1/ERR_W=8 and RD_LAT=2/ERR_W=4) run side by side against RAM models
// with per-address fault masks; results are predicted from the pattern rules and the masks.
module tb_ram_bist;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] seed = 8'd0;

    logic       busy_a, done_a, pass_a, en_a, we_a;
    logic [7:0] err_a, wd_a, rd_a;
    logic [4:0] fea_a, addr_a;
    logic       busy_b, done_b, pass_b, en_b, we_b;
    logic [3:0] err_b;
    logic [7:0] wd_b, rd_b, p1_b;
    logic [4:0] fea_b, addr_b;

    logic [7:0] mem_a [DEPTH];
    logic [7:0] mem_b [DEPTH];
    logic [7:0] or_a  [DEPTH];
    logic [7:0] xor_a [DEPTH];
    logic [7:0] or_b  [DEPTH];
    logic [7:0] xor_b [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_bist #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1), .ERR_W(8)) u_dut_a (
        .sys_clk(clk), .sys_rst(rst_n), .start(start), .mode(mode), .seed(seed),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .first_err_addr(fea_a),
        .ram_en(en_a), .ram_we(we_a), .ram_addr(addr_a), .ram_wr_data(wd_a), .ram_rd_data(rd_a)
    );

    ram_bist #(.DATA_W(8), .ADDR_W(5), .RD_LAT(2), .ERR_W(4)) u_dut_b (
        .sys_clk(clk), .sys_rst(rst_n), .start(start), .mode(mode), .seed(seed),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .first_err_addr(fea_b),
        .ram_en(en_b), .ram_we(we_b), .ram_addr(addr_b), .ram_wr_data(wd_b), .ram_rd_data(rd_b)
    );

    // RAM models: faults are applied on the read path as (stored | or) ^ xor.
    always @(posedge clk) begin
        if (en_a && we_a) mem_a[addr_a] <= wd_a;
        rd_a <= (en_a && !we_a) ? ((mem_a[addr_a] | or_a[addr_a]) ^ xor_a[addr_a]) : 8'h00;
        if (en_b && we_b) mem_b[addr_b] <= wd_b;
        p1_b <= (en_b && !we_b) ? ((mem_b[addr_b] | or_b[addr_b]) ^ xor_b[addr_b]) : 8'h00;
        rd_b <= p1_b;
    end

    function automatic int ref_pat(input int m, input int s, input int a);
        int v;
        case (m)
            0: return (s + a) % 256;
            1: return 255 - ((s + a) % 256);
            2: return (a % 2 == 1) ? 255 - s : s;
            default: begin
                v = s;
                repeat (a % 8) v = ((v * 2) % 256) + (v / 128);
                return v;
            end
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input string who, input int k, input int lat, input int m, input int s,
                             input logic en, input logic we, input logic [4:0] addr,
                             input logic [7:0] wd, input logic bsy, input logic dn, input logic ps,
                             input logic [7:0] err, input logic [4:0] fe,
                             input int xerr, input int xfirst, input int xpass);
        int dk;
        dk = 2 * DEPTH + lat + 1;
        if (k <= DEPTH) begin
            check_eq({who, "_wr_en"}, en, 1);
            check_eq({who, "_wr_we"}, we, 1);
            check_eq({who, "_wr_addr"}, addr, k - 1);
            check_eq({who, "_wr_data"}, wd, ref_pat(m, s, k - 1));
        end else if (k <= 2 * DEPTH) begin
            check_eq({who, "_rd_en"}, en, 1);
            check_eq({who, "_rd_we"}, we, 0);
            check_eq({who, "_rd_addr"}, addr, k - DEPTH - 1);
        end else begin
            check_eq({who, "_idle_en"}, en, 0);
        end
        check_eq({who, "_busy"}, bsy, (k < dk) ? 1 : 0);
        check_eq({who, "_done"}, dn, (k == dk) ? 1 : 0);
        if (k == 1) begin
            check_eq({who, "_clr_err"}, err, 0);
            check_eq({who, "_clr_pass"}, ps, 0);
        end
        if (k >= dk) begin
            check_eq({who, "_err_cnt"}, err, xerr);
            check_eq({who, "_first_err"}, fe, xfirst);
            check_eq({who, "_pass"}, ps, xpass);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_a_ctl"}, {busy_a, done_a, pass_a, en_a, we_a}, 0);
        check_eq({tag, "_a_err"}, err_a, 0);
        check_eq({tag, "_a_fea"}, fea_a, 0);
        check_eq({tag, "_a_addr"}, addr_a, 0);
        check_eq({tag, "_a_wd"}, wd_a, 0);
        check_eq({tag, "_b_ctl"}, {busy_b, done_b, pass_b, en_b, we_b}, 0);
        check_eq({tag, "_b_err"}, err_b, 0);
        check_eq({tag, "_b_fea"}, fea_b, 0);
        check_eq({tag, "_b_addr"}, addr_b, 0);
        check_eq({tag, "_b_wd"}, wd_b, 0);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            or_a[a] = 8'h00; xor_a[a] = 8'h00; or_b[a] = 8'h00; xor_b[a] = 8'h00;
        end
    endtask

    task automatic run_test(input int m, input int s);
        int ca, cb, fa, fb, p;
        ca = 0; cb = 0; fa = 0; fb = 0;
        for (int a = 0; a < DEPTH; a++) begin
            p = ref_pat(m, s, a);
            if (((p | int'(or_a[a])) ^ int'(xor_a[a])) != p) begin
                if (ca == 0) fa = a;
                ca++;
            end
            if (((p | int'(or_b[a])) ^ int'(xor_b[a])) != p) begin
                if (cb == 0) fb = a;
                cb++;
            end
        end
        @(negedge clk);
        mode  = 2'(m);
        seed  = 8'(s);
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * DEPTH + 6; k++) begin
            @(negedge clk);
            check_dut("a", k, 1, m, s, en_a, we_a, addr_a, wd_a, busy_a, done_a, pass_a, err_a,
                      fea_a, (ca > 255) ? 255 : ca, fa, (ca == 0) ? 1 : 0);
            check_dut("b", k, 2, m, s, en_b, we_b, addr_b, wd_b, busy_b, done_b, pass_b,
                      {4'd0, err_b}, fea_b, (cb > 15) ? 15 : cb, fb, (cb == 0) ? 1 : 0);
            start = (k < 48) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic reset_test();
        for (int a = 0; a < DEPTH; a++) begin
            xor_a[a] = 8'hFF; xor_b[a] = 8'hFF;
        end
        @(negedge clk);
        mode  = 2'd0;
        seed  = 8'($urandom_range(0, 255));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("mid_read_busy", {busy_a, busy_b, we_a, we_b}, 4'b1100);
        check_eq("mid_read_err_a", (err_a != 8'd0) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_eq("rst_no_done", {done_a, done_b, busy_a, busy_b}, 0);
        end
        rst_n = 1'b1;
        clear_faults();
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", {done_a, done_b, busy_a, busy_b, en_a, en_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_faults();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        run_test(0, 8'h00);
        run_test(2, 8'h55);
        or_a[5] = 8'h08;
        for (int a = 0; a < DEPTH; a++) xor_b[a] = 8'hFF;
        run_test(0, 8'h00);
        clear_faults();
        run_test(3, 8'h81);
        for (int a = 0; a < DEPTH; a++) xor_a[a] = 8'hFF;
        run_test(1, 8'h3C);
        clear_faults();

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                or_a[a]  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
                xor_a[a] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
                or_b[a]  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
                xor_b[a] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            run_test(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        end
        clear_faults();

        reset_test();
        run_test(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
